// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: four-source round-robin arbiter driving a registered 4:1
// data mux. A grantee may stream up to MAX_BURST back-to-back words while it
// keeps requesting; every burst ends with a mandatory one-cycle IDLE bubble in
// which arbitration restarts from the source after the last winner.
module mux_sel_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [10:0] din0,
   input  logic [10:0] din1,
   input  logic [10:0] din2,
   input  logic [10:0] din3,
   input  logic        dout_ready,
   output logic [1:0]  sel,
   output logic [3:0]  gnt,
   output logic [10:0] dout,
   output logic        dout_valid,
   output logic        busy
);

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [3:0]  gnt_q, gnt_d;
   logic [10:0] dout_q, dout_d;
   logic        vld_q, vld_d;
   logic [3:0]  burst_q, burst_d;
   logic [1:0]  last_q, last_d;

   logic [1:0]  win;
   logic [1:0]  idx;
   logic [10:0] din_win;
   logic [10:0] din_sel;
   logic        handshake;
   logic        burst_more;

   // Round-robin search: first set request starting at last winner + 1.
   // Scanning from the farthest candidate down lets the nearest one win.
   always_comb begin
      win = 2'd0;
      idx = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         idx = last_q + 2'(k + 1);
         if (req[idx]) begin
            win = idx;
         end
      end
   end

   // Data mux for the new winner (IDLE) and for the current grantee (XFER).
   always_comb begin
      case (win)
         2'd0:    din_win = din0;
         2'd1:    din_win = din1;
         2'd2:    din_win = din2;
         default: din_win = din3;
      endcase
      case (sel_q)
         2'd0:    din_sel = din0;
         2'd1:    din_sel = din1;
         2'd2:    din_sel = din2;
         default: din_sel = din3;
      endcase
   end

   assign handshake  = vld_q & dout_ready;
   // Another word fits in this burst only if the count after it stays below MAX_BURST.
   assign burst_more = ({1'b0, burst_q} + 5'd1) < 5'(MAX_BURST);

   // Next-state and output decode; everything holds unless a rule changes it.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      dout_d  = dout_q;
      vld_d   = vld_q;
      burst_d = burst_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            gnt_d = 4'b0000;
            vld_d = 1'b0;
            if (req != 4'b0000) begin
               state_d = XFER;
               sel_d   = win;
               gnt_d   = 4'b0001 << win;
               dout_d  = din_win;
               vld_d   = 1'b1;
               burst_d = 4'd0;
            end
         end
         XFER: begin
            // Without a handshake the presented word is held, even if req[sel] drops.
            if (handshake) begin
               if (req[sel_q] && burst_more) begin
                  dout_d  = din_sel;
                  burst_d = burst_q + 4'd1;
               end else begin
                  state_d = IDLE;
                  last_d  = sel_q;
                  gnt_d   = 4'b0000;
                  vld_d   = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            vld_d   = 1'b0;
         end
      endcase
   end

   // State register; reset parks last winner at 3 so source 0 is favoured first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         gnt_q   <= 4'b0000;
         dout_q  <= 11'd0;
         vld_q   <= 1'b0;
         burst_q <= 4'd0;
         last_q  <= 2'd3;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
         burst_q <= burst_d;
         last_q  <= last_d;
      end
   end

   assign sel        = sel_q;
   assign gnt        = gnt_q;
   assign dout       = dout_q;
   assign dout_valid = vld_q;
   assign busy       = (state_q == XFER);

endmodule
